bcd_timer_ctrl: RTL and testbench

Sequencer for a cascaded chain of BCD decade up-counters, forming a programmable multi-digit event timer. It loads a BCD preset into the chain and gates per-digit count enables from an external TICK strobe. It detects a programmed BCD terminal value, then either stops (one-shot) or reloads (auto-reload). It sits between the control/register logic and the decade-counter datapath, and replaces ad-hoc LD/EN/CAI glue around cascaded decade counters.

---
 rtl/bcd_pkg.sv | 31 +++
 rtl/bcd_timer_ctrl_if.sv | 27 ++
 rtl/bcd_digit.sv | 39 +++
 rtl/bcd_timer_ctrl.sv | 161 ++++++++++++++++
 tb/tb_bcd_timer_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types, constants and BCD helpers for the BCD event timer.
package bcd_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StRun  = 2'd2
   } state_e;

   localparam logic [3:0]  BCD_MAX    = 4'd9;
   localparam int unsigned MAX_DIGITS = 8;
   localparam int unsigned MAX_W      = 4 * MAX_DIGITS;

   function automatic logic bcd_valid(input logic [3:0] nibble);
      return nibble <= BCD_MAX;
   endfunction

   // Checks the low 'digits' nibbles of a zero-extended value.
   function automatic logic bcd_all_valid(input logic [MAX_W-1:0] value,
                                          input int unsigned digits);
      logic ok;
      ok = 1'b1;
      for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
         if (i < digits && !bcd_valid(value[4*i +: 4])) begin
            ok = 1'b0;
         end
      end
      return ok;
   endfunction

endpackage

// File: rtl/bcd_timer_ctrl_if.sv
// Control/status bundle between register logic and the BCD timer.
interface bcd_timer_ctrl_if #(
   parameter int unsigned Digits = 4
) ();

   logic                  start;
   logic                  stop;
   logic                  mode;
   logic [4*Digits-1:0]   preset;
   logic [4*Digits-1:0]   limit;
   logic                  tick;
   logic [4*Digits-1:0]   count;
   logic                  busy;
   logic                  done;
   logic                  err;

   modport master (
      output start, stop, mode, preset, limit, tick,
      input  count, busy, done, err
   );

   modport slave (
      input  start, stop, mode, preset, limit, tick,
      output count, busy, done, err
   );

endinterface

// File: rtl/bcd_digit.sv
// One decade stage: synchronous load, count on carry-in, carry-out at 9.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ld_i,
   input  logic [3:0] d_i,
   input  logic       cai_i,
   input  logic       en_i,
   output logic [3:0] q_o,
   output logic       cao_o
);

   logic [3:0] q_d, q_q;

   // Load wins over counting; a stage at 9 wraps to 0.
   always_comb begin
      q_d = q_q;
      if (ld_i) begin
         q_d = d_i;
      end else if (en_i && cai_i) begin
         q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
      end
   end

   // Digit register, cleared by the controller reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= 4'd0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o   = q_q;
   assign cao_o = en_i && cai_i && (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Sequencer for a cascaded BCD decade counter chain with one-shot/auto-reload.
module bcd_timer_ctrl
   import bcd_pkg::*;
#(
   parameter int unsigned Digits = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bcd_timer_ctrl_if.slave       bus
);

   localparam int unsigned W = 4 * Digits;

   state_e         state_d, state_q;
   logic [W-1:0]   preset_d, preset_q;
   logic [W-1:0]   limit_d, limit_q;
   logic           mode_d, mode_q;
   logic           busy_d, busy_q;
   logic           done_d, done_q;
   logic           err_d, err_q;

   logic           start_ok;
   logic           hit;
   logic           capture;
   logic           ld;
   logic           cai0;
   logic           run;
   logic [W-1:0]   count_w;
   logic [Digits:0] carry;
   logic           unused_carry_top;

   assign start_ok = bcd_all_valid(MAX_W'(bus.preset), Digits) &&
                     bcd_all_valid(MAX_W'(bus.limit), Digits);
   assign hit      = (count_w == limit_q);
   assign run      = (state_q == StRun);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; in RUN the priority is STOP > START > TICK.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start && start_ok) state_d = StLoad;
         end
         StLoad: begin
            state_d = StRun;
         end
         StRun: begin
            if (bus.stop) begin
               state_d = StIdle;
            end else if (bus.start) begin
               if (start_ok) state_d = StLoad;
            end else if (bus.tick && hit && !mode_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output decode: capture, chain load, chain carry-in and status pulses.
   always_comb begin
      capture = 1'b0;
      ld      = 1'b0;
      cai0    = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               if (start_ok) capture = 1'b1;
               else          err_d   = 1'b1;
            end
         end
         StLoad: begin
            ld = 1'b1;
         end
         StRun: begin
            if (bus.stop) begin
               // Abort: count holds.
            end else if (bus.start) begin
               if (start_ok) capture = 1'b1;
               else          err_d   = 1'b1;
            end else if (bus.tick) begin
               if (hit) begin
                  done_d = 1'b1;
                  // Reload replaces the increment so no tick is lost.
                  ld     = mode_q;
               end else begin
                  cai0 = 1'b1;
               end
            end
         end
         default: ;
      endcase
      busy_d = (state_d != StIdle);
   end

   // Settings are only captured on an accepted START.
   always_comb begin
      preset_d = preset_q;
      limit_d  = limit_q;
      mode_d   = mode_q;
      if (capture) begin
         preset_d = bus.preset;
         limit_d  = bus.limit;
         mode_d   = bus.mode;
      end
   end

   // Capture and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         preset_q <= '0;
         limit_q  <= '0;
         mode_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         preset_q <= preset_d;
         limit_q  <= limit_d;
         mode_q   <= mode_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign carry[0] = cai0;

   for (genvar i = 0; i < Digits; i++) begin : g_digit
      bcd_digit u_digit (
         .clk   (clk),
         .rst_n (rst_n),
         .ld_i  (ld),
         .d_i   (preset_q[4*i +: 4]),
         .cai_i (carry[i]),
         .en_i  (run),
         .q_o   (count_w[4*i +: 4]),
         .cao_o (carry[i+1])
      );
   end

   // Full-chain wrap carries no flag.
   assign unused_carry_top = carry[Digits];

   assign bus.count = count_w;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl against a decimal-arithmetic model.
module tb_bcd_timer_ctrl;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   bcd_timer_ctrl_if #(.Digits(4)) bus ();

   bcd_timer_ctrl #(.Digits(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain decimal integers and a phase number.
   int   m_phase;   // 0 idle, 1 loading, 2 running
   int   m_cnt;
   int   m_preset;
   int   m_limit;
   bit   m_mode;
   bit   m_done;
   bit   m_err;

   function automatic int to_dec(input logic [15:0] b);
      int v;
      v = 0;
      for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
      return v;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int x;
      x = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic bit all_digits(input logic [15:0] b);
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_cnt = 0; m_preset = 0; m_limit = 0; m_mode = 0;
      m_done = 0; m_err = 0;
   endtask

   task automatic try_start();
      if (all_digits(bus.preset) && all_digits(bus.limit)) begin
         m_preset = to_dec(bus.preset);
         m_limit  = to_dec(bus.limit);
         m_mode   = bus.mode;
         m_phase  = 1;
      end else begin
         m_err = 1;
      end
   endtask

   task automatic model_step();
      m_done = 0;
      m_err  = 0;
      if (m_phase == 0) begin
         if (bus.start) try_start();
      end else if (m_phase == 1) begin
         m_cnt   = m_preset;
         m_phase = 2;
      end else begin
         if (bus.stop) begin
            m_phase = 0;
         end else if (bus.start) begin
            try_start();
         end else if (bus.tick) begin
            if (m_cnt == m_limit) begin
               m_done = 1;
               if (m_mode) m_cnt = m_preset;
               else        m_phase = 0;
            end else begin
               m_cnt = (m_cnt + 1) % 10000;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
   endtask

   task automatic check_all();
      chk("count", 32'(bus.count), 32'(to_bcd(m_cnt)));
      chk("busy",  32'(bus.busy),  32'(m_phase != 0));
      chk("done",  32'(bus.done),  32'(m_done));
      chk("err",   32'(bus.err),   32'(m_err));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic go(input logic [15:0] p, input logic [15:0] l, input logic md);
      bus.start  = 1'b1;
      bus.preset = p;
      bus.limit  = l;
      bus.mode   = md;
      cycle();
      bus.start  = 1'b0;
      bus.preset = $urandom;  // don't-care outside START
      bus.limit  = $urandom;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.stop   = 1'b0;
      bus.mode   = 1'b0;
      bus.preset = '0;
      bus.limit  = '0;
      bus.tick   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_all();

      // One-shot across a digit carry.
      go(16'h0095, 16'h0103, 1'b0);
      bus.tick = 1'b1;
      repeat (13) cycle();
      bus.tick = 1'b0;
      cycle();

      // Auto-reload through full wrap.
      go(16'h9998, 16'h0001, 1'b1);
      bus.tick = 1'b1;
      repeat (14) cycle();
      bus.stop = 1'b1;
      cycle();
      bus.stop = 1'b0;
      bus.tick = 1'b0;
      cycle();

      // Invalid BCD in IDLE, then in RUN.
      go(16'h00A0, 16'h0000, 1'b0);
      cycle();
      go(16'h0010, 16'h0500, 1'b0);
      bus.tick = 1'b1;
      repeat (4) cycle();
      bus.tick = 1'b0;
      go(16'h00A0, 16'h0200, 1'b1);
      bus.tick = 1'b1;
      repeat (4) cycle();

      // Priority: STOP beats START and TICK.
      bus.stop = 1'b1; bus.start = 1'b1; bus.preset = 16'h0001; bus.limit = 16'h0002;
      cycle();
      bus.stop = 1'b0; bus.start = 1'b0; bus.tick = 1'b0;
      cycle();
      // START beats TICK in RUN; TICK in LOAD is dropped.
      go(16'h0300, 16'h0400, 1'b0);
      bus.tick = 1'b1;
      repeat (3) cycle();
      go(16'h0020, 16'h0030, 1'b0);
      repeat (4) cycle();
      bus.tick = 1'b0;
      bus.stop = 1'b1;
      cycle();
      bus.stop = 1'b0;

      // Gapped ticks with PRESET == LIMIT.
      go(16'h0007, 16'h0007, 1'b0);
      for (int k = 0; k < 9; k++) begin
         bus.tick = (k % 3 == 2);
         cycle();
      end
      bus.tick = 1'b0;

      // Asynchronous reset mid-run.
      go(16'h0123, 16'h9999, 1'b0);
      cycle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_count", 32'(bus.count), 32'h0);
      chk("rst_busy",  32'(bus.busy),  32'h0);
      chk("rst_done",  32'(bus.done),  32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      bus.tick = 1'b1;
      repeat (3) cycle();

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         logic [15:0] p;
         logic [15:0] l;
         p = to_bcd(int'($urandom_range(0, 9999)));
         l = to_bcd((to_dec(p) + int'($urandom_range(0, 20))) % 10000);
         if ($urandom_range(0, 7) == 0) begin
            p[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
         end
         bus.start  = ($urandom_range(0, 15) == 0);
         bus.stop   = ($urandom_range(0, 39) == 0);
         bus.tick   = ($urandom_range(0, 3) != 0);
         bus.mode   = 1'($urandom);
         bus.preset = p;
         bus.limit  = l;
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
